// File: rtl/mem_line_responder_pkg.sv
// Shared memory-message and responder FSM encodings, also imported by the
// cache controllers so request/response types stay consistent.
package mem_line_responder_pkg;

  typedef enum logic [1:0] {
    MEM_READ       = 2'd0,
    MEM_WRITE      = 2'd1,
    MEM_WRITE_INIT = 2'd2,
    MEM_RSVD       = 2'd3
  } mem_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_e;

  function automatic logic is_write(input mem_type_e t);
    return (t == MEM_WRITE) || (t == MEM_WRITE_INIT);
  endfunction

endpackage

// File: rtl/mem_line_array.sv
// Line storage: one synchronous write port, one registered read port,
// and a synchronous clear of every line while reset is high.
module mem_line_array #(
  parameter int nlines = 64,
  parameter int clw    = 128,
  parameter int iw     = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [iw-1:0]  wr_idx,
  input  logic [clw-1:0] wr_data,
  input  logic           rd_en,
  input  logic [iw-1:0]  rd_idx,
  output logic [clw-1:0] rd_data
);

  logic [clw-1:0] mem_reg [nlines];
  logic [clw-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < nlines; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[wr_idx] <= wr_data;
    end
  end

  // The read register only moves on rd_en so it doubles as a stable response holder.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem_reg[rd_idx];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/mem_line_responder.sv
// Single-outstanding memory responder: accepts one line request, waits a
// fixed latency, then offers the response until it is taken.
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int nlines  = 64,
  parameter int clw     = 128,
  parameter int latency = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           memreq_val,
  output logic           memreq_rdy,
  input  logic [1:0]     memreq_type,
  input  logic [31:0]    memreq_addr,
  input  logic [clw-1:0] memreq_data,
  output logic           memresp_val,
  input  logic           memresp_rdy,
  output logic [1:0]     memresp_type,
  output logic [clw-1:0] memresp_data
);

  localparam int IW = (nlines > 1) ? $clog2(nlines) : 1;
  localparam int CW = (latency > 1) ? $clog2(latency) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((latency > 0) ? latency - 1 : 0);

  resp_state_e    state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  mem_type_e      type_reg;
  logic [IW-1:0]  idx_reg;
  logic [clw-1:0] data_reg;

  logic           req_fire;
  logic           enter_resp;
  mem_type_e      eff_type;
  logic [IW-1:0]  eff_idx;
  logic [clw-1:0] eff_data;
  logic           wr_en;
  logic           rd_en;
  logic [clw-1:0] rd_data;
  logic           resp_active;

  assign req_fire = (state_reg == ST_IDLE) && memreq_val;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_fire) begin
          if (latency == 0) begin
            state_next = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == '0) begin
          state_next = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ST_RESP: begin
        if (memresp_rdy) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // With zero latency the storage access happens on the acceptance edge,
  // before the request fields have landed in the latches.
  assign eff_type = (state_reg == ST_IDLE) ? mem_type_e'(memreq_type) : type_reg;
  assign eff_idx  = (state_reg == ST_IDLE) ? memreq_addr[4 +: IW] : idx_reg;
  assign eff_data = (state_reg == ST_IDLE) ? memreq_data : data_reg;

  assign wr_en = enter_resp && !reset && is_write(eff_type);
  assign rd_en = enter_resp && !reset && (eff_type == MEM_READ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      type_reg  <= MEM_READ;
      idx_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (req_fire) begin
        type_reg <= mem_type_e'(memreq_type);
        idx_reg  <= memreq_addr[4 +: IW];
        data_reg <= memreq_data;
      end
    end
  end

  mem_line_array #(
    .nlines (nlines),
    .clw    (clw),
    .iw     (IW)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_idx  (eff_idx),
    .wr_data (eff_data),
    .rd_en   (rd_en),
    .rd_idx  (eff_idx),
    .rd_data (rd_data)
  );

  assign resp_active  = (state_reg == ST_RESP) && !reset;
  assign memreq_rdy   = (state_reg == ST_IDLE) && !reset;
  assign memresp_val  = resp_active;
  assign memresp_type = resp_active ? 2'(type_reg) : 2'b00;
  assign memresp_data = (resp_active && type_reg == MEM_READ) ? rd_data : '0;

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: directed corner cases plus random traffic
// against an array-based model of line storage.
module tb_mem_line_responder;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [1:0]   memreq_type, memresp_type;
  logic [31:0]  memreq_addr;
  logic [127:0] memreq_data, memresp_data;

  logic         memreq_val0, memreq_rdy0, memresp_val0, memresp_rdy0;
  logic [1:0]   memreq_type0, memresp_type0;
  logic [31:0]  memreq_addr0;
  logic [127:0] memreq_data0, memresp_data0;

  logic [127:0] model [64];
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mem_line_responder #(.nlines(64), .clw(128), .latency(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .memreq_val   (memreq_val),
    .memreq_rdy   (memreq_rdy),
    .memreq_type  (memreq_type),
    .memreq_addr  (memreq_addr),
    .memreq_data  (memreq_data),
    .memresp_val  (memresp_val),
    .memresp_rdy  (memresp_rdy),
    .memresp_type (memresp_type),
    .memresp_data (memresp_data)
  );

  mem_line_responder #(.nlines(64), .clw(128), .latency(0)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .memreq_val   (memreq_val0),
    .memreq_rdy   (memreq_rdy0),
    .memreq_type  (memreq_type0),
    .memreq_addr  (memreq_addr0),
    .memreq_data  (memreq_data0),
    .memresp_val  (memresp_val0),
    .memresp_rdy  (memresp_rdy0),
    .memresp_type (memresp_type0),
    .memresp_data (memresp_data0)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model[i] = '0;
  endtask

  // Called and returns on a falling edge with the responder idle.
  task automatic do_txn(input logic [1:0] t, input logic [31:0] a,
                        input logic [127:0] d, input int stall);
    logic [127:0] exp_data;
    logic [127:0] hold_data;
    logic [1:0]   hold_type;
    int idx;
    int n;
    idx = int'(a[9:4]);
    exp_data = (t == 2'd0) ? model[idx] : 128'd0;
    if (t == 2'd1 || t == 2'd2) model[idx] = d;

    check("req_rdy_idle", {127'd0, memreq_rdy}, 128'd1);
    memreq_val  = 1'b1;
    memreq_type = t;
    memreq_addr = a;
    memreq_data = d;
    @(posedge clk); #1;
    memreq_val = 1'b0;

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (memresp_val !== 1'b1 && n < 20);
    check("resp_latency", 128'(n), 128'(LAT + 1));
    check("resp_type", {126'd0, memresp_type}, {126'd0, t});
    check("resp_data", memresp_data, exp_data);
    hold_type = memresp_type;
    hold_data = memresp_data;

    // Offer a conflicting write while the response is pending; it must be ignored.
    memreq_val  = 1'b1;
    memreq_type = 2'd1;
    memreq_addr = $urandom();
    memreq_data = {4{$urandom()}};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_val", {127'd0, memresp_val}, 128'd1);
      check("hold_type", {126'd0, memresp_type}, {126'd0, hold_type});
      check("hold_data", memresp_data, hold_data);
      check("hold_req_rdy", {127'd0, memreq_rdy}, 128'd0);
    end
    memresp_rdy = 1'b1;
    @(posedge clk); #1;
    memresp_rdy = 1'b0;
    memreq_val  = 1'b0;
    @(negedge clk);
    check("req_rdy_after", {127'd0, memreq_rdy}, 128'd1);
    check("resp_val_after", {127'd0, memresp_val}, 128'd0);
  endtask

  initial begin
    logic [31:0]  a;
    logic [127:0] d;
    logic [1:0]   t;

    reset = 1'b1;
    memreq_val = 1'b0; memreq_type = 2'd0; memreq_addr = '0; memreq_data = '0;
    memresp_rdy = 1'b0;
    memreq_val0 = 1'b0; memreq_type0 = 2'd0; memreq_addr0 = '0; memreq_data0 = '0;
    memresp_rdy0 = 1'b0;
    clear_model();

    repeat (3) @(negedge clk);
    check("rst_req_rdy", {127'd0, memreq_rdy}, 128'd0);
    check("rst_resp_val", {127'd0, memresp_val}, 128'd0);
    check("rst_resp_type", {126'd0, memresp_type}, 128'd0);
    check("rst_resp_data", memresp_data, 128'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", {127'd0, memreq_rdy}, 128'd1);

    // Write then read back the same line, the read held off for 5 cycles.
    do_txn(2'd1, 32'h40, {16{8'hA5}}, 0);
    do_txn(2'd0, 32'h40, 128'd0, 5);

    // Index wrap: 0x400 lands on line 0.
    do_txn(2'd1, 32'h400, 128'd1, 1);
    do_txn(2'd0, 32'h0, 128'd0, 0);

    // Write-init and reserved types.
    do_txn(2'd2, 32'h50, {4{32'hDEADBEEF}}, 0);
    do_txn(2'd3, 32'h50, {4{32'h12345678}}, 0);
    do_txn(2'd0, 32'h50, 128'd0, 2);

    // Reset in WAIT drops a write and clears all lines.
    memreq_val = 1'b1; memreq_type = 2'd1; memreq_addr = 32'h80;
    memreq_data = {4{32'hCAFEF00D}};
    @(posedge clk); #1;
    memreq_val = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("wait_rst_val", {127'd0, memresp_val}, 128'd0);
    check("wait_rst_rdy", {127'd0, memreq_rdy}, 128'd0);
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    check("wait_rst_after_val", {127'd0, memresp_val}, 128'd0);
    do_txn(2'd0, 32'h80, 128'd0, 0);
    do_txn(2'd0, 32'h40, 128'd0, 0);

    // Random traffic concentrated on a few lines so reads hit earlier writes.
    for (int k = 0; k < 40; k++) begin
      a = $urandom();
      a[9:4] = 6'($urandom_range(0, 7));
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      t = 2'($urandom_range(0, 3));
      do_txn(t, a, d, int'($urandom_range(0, 3)));
    end

    // Zero-latency instance with a continuous read stream.
    memreq_val0 = 1'b1;
    memreq_type0 = 2'd0;
    memreq_addr0 = $urandom();
    memresp_rdy0 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check("lat0_val", {127'd0, memresp_val0}, (k % 2 == 1) ? 128'd1 : 128'd0);
      check("lat0_rdy", {127'd0, memreq_rdy0}, (k % 2 == 0) ? 128'd1 : 128'd0);
      check("lat0_data", memresp_data0, 128'd0);
      @(negedge clk);
    end
    memreq_val0 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

Interface
REQ-001: Parameter nlines, default 64; number of 128-bit lines stored.
REQ-002: Parameter clw, default 128; line width in bits.
REQ-003: Parameter latency, default 2; extra cycles in WAIT before a response is offered.
REQ-004: clk  in  1  clock; all state updates on the rising edge.
REQ-005: reset  in  1  synchronous, active-high reset.
REQ-006: memreq_val  in  1  request valid.
REQ-007: memreq_rdy  out  1  responder can accept a request.
REQ-008: memreq_type  in  2  request type: 0 read, 1 write, 2 write-init, 3 reserved.
REQ-009: memreq_addr  in  32  byte address; bits [3:0] ignored.
REQ-010: memreq_data  in  clw  write line data.
REQ-011: memresp_val  out  1  response valid.
REQ-012: memresp_rdy  in  1  requester accepts the response.
REQ-013: memresp_type  out  2  echo of the accepted request type.
REQ-014: memresp_data  out  clw  read line data; zero for writes and reserved types.

Function
REQ-015: The block SHALL implement FSM IDLE, WAIT and RESP, with exactly one request outstanding.
REQ-016: memreq_rdy SHALL be 1 only in IDLE; memresp_val SHALL be 1 only in RESP.
REQ-017: When memreq_val and memreq_rdy are both 1 in IDLE, the block SHALL latch type, index = addr[4 +: log2(nlines)] (upper bits ignored, wrap modulo nlines) and data, and SHALL enter WAIT, or RESP when latency = 0.
REQ-018: WAIT SHALL load a counter with latency-1, decrement it each cycle, and enter RESP on the cycle it reads 0.
REQ-019: memresp_val SHALL first assert latency+1 cycles after the acceptance edge.
REQ-020: On entry to RESP, a write or write-init SHALL store the latched data at the latched index, and a read SHALL capture the stored line into the response register.
REQ-021: Write and write-init SHALL behave identically in storage.
REQ-022: The reserved type SHALL not modify storage and SHALL return zero data.
REQ-023: While RESP waits for memresp_rdy, memresp_val, memresp_type and memresp_data SHALL hold stable.
REQ-024: On a cycle where memresp_val and memresp_rdy are both 1, the block SHALL return to IDLE, and memreq_rdy SHALL be 1 on the next cycle.
REQ-025: A request offered in the same cycle as the response handshake SHALL NOT be accepted, because memreq_rdy is 0 in RESP.
REQ-026: A read of a line written by the previous transaction SHALL return the new data.

Reset
REQ-027: While reset = 1, the state SHALL go to IDLE and every storage line SHALL clear to zero.
REQ-028: While reset = 1, memreq_rdy, memresp_val, memresp_type and memresp_data SHALL be 0.
REQ-029: Reset asserted in WAIT or RESP SHALL drop the pending transaction without writing storage.
REQ-030: memreq_rdy SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-031: Memory message type encodings and the FSM state encoding SHALL live in a shared package, also used by the cache controllers.
REQ-032: The storage array SHALL be a sub-module, mem_line_array, with one synchronous write port, one read port and synchronous clear.

Verification
REQ-033: Latency 2: write type 1, addr 0x40, data 0xA5A5...A5 -> memresp_val high 3 cycles after accept, type 1, data 0.
REQ-034: Read addr 0x40 after REQ-033 -> type 0, data 0xA5A5...A5.
REQ-035: Hold memresp_rdy = 0 for 5 cycles during a response -> memresp_val and memresp_data stable, memreq_rdy = 0 throughout.
REQ-036: nlines 64: write addr 0x400 with data 0x1, then read addr 0x0 -> data 0x1 (index wrap).
REQ-037: Reset asserted during WAIT of a write to addr 0x80 -> next read of 0x80 returns 0, memresp_val low the cycle after reset.
REQ-038: Latency 0, back-to-back reads with memresp_rdy held 1 -> one response every 2 cycles, memreq_rdy never high in the handshake cycle.
